// File: rtl/io_ps2_pkg.sv
// Shared definitions for the PS/2 hub: register offsets, STATUS bit positions, TX FSM states.
package io_ps2_pkg;

    // Per-channel register offsets within the 4-byte channel window
    localparam logic [1:0] OFS_DATA   = 2'd0;
    localparam logic [1:0] OFS_STATUS = 2'd1;
    localparam logic [1:0] OFS_COUNT  = 2'd2;
    localparam logic [1:0] OFS_CTRL   = 2'd3;

    // STATUS register bit indices
    localparam int unsigned ST_TX_DONE  = 0;
    localparam int unsigned ST_EMPTY    = 1;
    localparam int unsigned ST_FULL     = 2;
    localparam int unsigned ST_OVERFLOW = 3;
    localparam int unsigned ST_TX_BUSY  = 4;
    localparam int unsigned ST_TX_ERR   = 5;
    localparam int unsigned ST_CMD_DROP = 6;
    localparam int unsigned ST_IRQ_EN   = 7;

    // CTRL register bit indices
    localparam int unsigned CTRL_FLUSH  = 0;
    localparam int unsigned CTRL_CLEAR  = 1;
    localparam int unsigned CTRL_IRQ_EN = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } tx_state_e;

endpackage

// File: rtl/io_ps2_chan.sv
// One PS/2 channel: RX FIFO, command-transmit FSM, sticky status bits and local register mux.
module io_ps2_chan
    import io_ps2_pkg::*;
#(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned TX_TIMEOUT = 2_500_000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] ofs,
    input  logic [7:0] wdata,
    input  logic       wr_en,
    input  logic       rd_en,
    output logic [7:0] rdata,
    input  logic [7:0] rx_data,
    input  logic       rx_hit,
    output logic [7:0] tx_cmd,
    output logic       tx_send,
    input  logic       tx_done,
    input  logic       tx_err,
    output logic       irq
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(TX_TIMEOUT);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push;
    logic          flush;
    logic          clr;
    logic          ctrl_wr;
    logic          cmd_wr;
    logic          ovf_event;

    logic          overflow;
    logic          irq_en;
    logic          sticky_done;
    logic          sticky_err;
    logic          cmd_drop;
    tx_state_e     state;
    logic [TW-1:0] timer;
    logic [7:0]    status;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign ctrl_wr = wr_en && (ofs == OFS_CTRL);
    assign cmd_wr  = wr_en && (ofs == OFS_DATA);
    assign flush   = ctrl_wr && wdata[CTRL_FLUSH];
    assign clr     = ctrl_wr && wdata[CTRL_CLEAR];
    assign pop     = rd_en && (ofs == OFS_DATA) && !empty;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push
    assign push      = rx_hit && !flush && (!full || pop);
    assign ovf_event = rx_hit && !flush && full && !pop;

    assign irq = irq_en && !empty;

    // FIFO pointers and occupancy; flush overrides any push/pop in the same cycle
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    // FIFO storage; contents need no reset since empty reads are forced to 0
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= rx_data;
    end

    // Overflow sticky bit and interrupt enable; a new event beats a clear
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
            irq_en   <= 1'b0;
        end else begin
            if (ovf_event)    overflow <= 1'b1;
            else if (clr)     overflow <= 1'b0;
            if (ctrl_wr)      irq_en   <= wdata[CTRL_IRQ_EN];
        end
    end

    // TX FSM with registered send pulse, command latch and its sticky status bits
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            tx_send     <= 1'b0;
            tx_cmd      <= 8'h00;
            timer       <= '0;
            sticky_done <= 1'b0;
            sticky_err  <= 1'b0;
            cmd_drop    <= 1'b0;
        end else begin
            tx_send <= 1'b0;
            // Clear first so that any event below in the same cycle wins
            if (clr) begin
                sticky_done <= 1'b0;
                sticky_err  <= 1'b0;
                cmd_drop    <= 1'b0;
            end
            if (cmd_wr && state != IDLE) cmd_drop <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (cmd_wr) begin
                        tx_cmd  <= wdata;
                        tx_send <= 1'b1;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (tx_err || timer == TW'(TX_TIMEOUT - 1)) begin
                        sticky_err <= 1'b1;
                        state      <= IDLE;
                    end else if (tx_done) begin
                        sticky_done <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // STATUS assembly
    always_comb begin
        status              = 8'h00;
        status[ST_TX_DONE]  = sticky_done;
        status[ST_EMPTY]    = empty;
        status[ST_FULL]     = full;
        status[ST_OVERFLOW] = overflow;
        status[ST_TX_BUSY]  = (state != IDLE);
        status[ST_TX_ERR]   = sticky_err;
        status[ST_CMD_DROP] = cmd_drop;
        status[ST_IRQ_EN]   = irq_en;
    end

    // Local register read mux, reflecting state before the next edge
    always_comb begin
        rdata = 8'h00;
        unique case (ofs)
            OFS_DATA:   rdata = empty ? 8'h00 : mem[rd_ptr];
            OFS_STATUS: rdata = status;
            OFS_COUNT:  rdata = 8'(count);
            OFS_CTRL:   rdata = {7'b0, irq_en};
            default:    rdata = 8'h00;
        endcase
    end

endmodule

// File: rtl/io_ps2_hub.sv
// PS/2 hub top: address window decode, per-channel instances, read mux and interrupt OR.
module io_ps2_hub
    import io_ps2_pkg::*;
#(
    parameter int unsigned CHANNELS   = 2,
    parameter int unsigned DEPTH      = 8,
    parameter logic [15:0] BASE       = 16'hFFA0,
    parameter int unsigned TX_TIMEOUT = 2_500_000
) (
    input  logic                  CLOCK,
    input  logic                  RESET_N,
    input  logic [15:0]           ADDR,
    input  logic [7:0]            WDATA,
    input  logic                  WREN,
    input  logic                  RDEN,
    output logic [7:0]            RDATA,
    output logic                  SEL,
    input  logic [8*CHANNELS-1:0] RX_DATA,
    input  logic [CHANNELS-1:0]   RX_HIT,
    output logic [8*CHANNELS-1:0] TX_CMD,
    output logic [CHANNELS-1:0]   TX_SEND,
    input  logic [CHANNELS-1:0]   TX_DONE,
    input  logic [CHANNELS-1:0]   TX_ERR,
    output logic                  IRQ
);

    logic [15:0]         rel;
    logic [2:0]          chan_idx;
    logic [1:0]          ofs;
    logic [CHANNELS-1:0] chan_hit;
    logic [CHANNELS-1:0] chan_irq;
    logic [7:0]          chan_rdata [CHANNELS];

    // Addresses below BASE wrap to large values and fall outside the window
    assign rel      = ADDR - BASE;
    assign SEL      = (rel < 16'(4 * CHANNELS));
    assign chan_idx = rel[4:2];
    assign ofs      = rel[1:0];
    assign IRQ      = |chan_irq;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        assign chan_hit[c] = SEL && (chan_idx == 3'(c));

        io_ps2_chan #(
            .DEPTH      (DEPTH),
            .TX_TIMEOUT (TX_TIMEOUT)
        ) u_chan (
            .clock   (CLOCK),
            .reset_n (RESET_N),
            .ofs     (ofs),
            .wdata   (WDATA),
            .wr_en   (WREN && chan_hit[c]),
            .rd_en   (RDEN && chan_hit[c]),
            .rdata   (chan_rdata[c]),
            .rx_data (RX_DATA[8*c +: 8]),
            .rx_hit  (RX_HIT[c]),
            .tx_cmd  (TX_CMD[8*c +: 8]),
            .tx_send (TX_SEND[c]),
            .tx_done (TX_DONE[c]),
            .tx_err  (TX_ERR[c]),
            .irq     (chan_irq[c])
        );
    end

    // Read data mux; zero outside the window
    always_comb begin
        RDATA = 8'h00;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (chan_hit[c]) RDATA = chan_rdata[c];
        end
    end

endmodule

// File: tb/tb_io_ps2_hub.sv
// Directed self-checking bench for io_ps2_hub (2 channels, depth 8, 16-cycle TX timeout).
module tb_io_ps2_hub;

    localparam logic [15:0] BASE = 16'hFFA0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        wren;
    logic        rden;
    logic [7:0]  rdata;
    logic        sel;
    logic [15:0] rx_data;
    logic [1:0]  rx_hit;
    logic [15:0] tx_cmd;
    logic [1:0]  tx_send;
    logic [1:0]  tx_done;
    logic [1:0]  tx_err;
    logic        irq;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    io_ps2_hub #(
        .CHANNELS   (2),
        .DEPTH      (8),
        .BASE       (BASE),
        .TX_TIMEOUT (16)
    ) dut (
        .CLOCK   (clk),
        .RESET_N (rst_n),
        .ADDR    (addr),
        .WDATA   (wdata),
        .WREN    (wren),
        .RDEN    (rden),
        .RDATA   (rdata),
        .SEL     (sel),
        .RX_DATA (rx_data),
        .RX_HIT  (rx_hit),
        .TX_CMD  (tx_cmd),
        .TX_SEND (tx_send),
        .TX_DONE (tx_done),
        .TX_ERR  (tx_err),
        .IRQ     (irq)
    );

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Sample a register just before the next edge, optionally popping at that edge
    task automatic read_reg(input logic [15:0] a, input logic pop, output logic [7:0] d);
        addr = a;
        rden = pop;
        #1;
        d = rdata;
        @(posedge clk);
        #1;
        rden = 1'b0;
    endtask

    task automatic wr_reg(input logic [15:0] a, input logic [7:0] d);
        addr  = a;
        wdata = d;
        wren  = 1'b1;
        @(posedge clk);
        #1;
        wren = 1'b0;
    endtask

    task automatic push(input int c, input logic [7:0] d);
        rx_data[8*c +: 8] = d;
        rx_hit[c] = 1'b1;
        tick();
        rx_hit[c] = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] exp;

        rst_n   = 1'b0;
        addr    = 16'h0000;
        wdata   = 8'h00;
        wren    = 1'b0;
        rden    = 1'b0;
        rx_data = 16'h0000;
        rx_hit  = 2'b00;
        tx_done = 2'b00;
        tx_err  = 2'b00;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        read_reg(BASE + 16'd1, 1'b0, d);  check8("rst_status0", d, 8'h02);
        read_reg(BASE + 16'd2, 1'b0, d);  check8("rst_count0", d, 8'h00);
        read_reg(BASE + 16'd5, 1'b0, d);  check8("rst_status1", d, 8'h02);
        check1("rst_irq", irq, 1'b0);
        check1("rst_send1", tx_send[1], 1'b0);
        check8("rst_cmd1", tx_cmd[15:8], 8'h00);

        // Window decode
        addr = 16'h1234;        #1; check1("sel_out", sel, 1'b0); check8("rdata_out", rdata, 8'h00);
        addr = BASE - 16'd1;    #1; check1("sel_below", sel, 1'b0);
        addr = BASE + 16'd7;    #1; check1("sel_top", sel, 1'b1);
        addr = BASE + 16'd8;    #1; check1("sel_above", sel, 1'b0);

        // Channel 0 RX, interrupt and pops
        push(0, 8'h1C);
        push(0, 8'hF0);
        wr_reg(BASE + 16'd3, 8'h04);
        check1("irq_on", irq, 1'b1);
        read_reg(BASE + 16'd2, 1'b0, d);  check8("count0_2", d, 8'h02);
        read_reg(BASE + 16'd3, 1'b0, d);  check8("ctrl0_rd", d, 8'h01);
        read_reg(BASE, 1'b1, d);          check8("pop0_a", d, 8'h1C);
        check1("irq_mid", irq, 1'b1);
        read_reg(BASE, 1'b1, d);          check8("pop0_b", d, 8'hF0);
        check1("irq_off", irq, 1'b0);
        read_reg(BASE, 1'b1, d);          check8("pop0_empty", d, 8'h00);
        read_reg(BASE + 16'd1, 1'b0, d);  check8("status0_ien", d, 8'h82);

        // Channel 1 overflow
        for (int i = 1; i <= 9; i++) push(1, 8'(i));
        read_reg(BASE + 16'd6, 1'b0, d);  check8("count1_full", d, 8'h08);
        read_reg(BASE + 16'd5, 1'b0, d);  check8("status1_ovf", d, 8'h0C);
        wr_reg(BASE + 16'd7, 8'h02);
        read_reg(BASE + 16'd5, 1'b0, d);  check8("status1_clr", d, 8'h04);

        // Push and pop together while full
        addr = BASE + 16'd4;
        rden = 1'b1;
        rx_data[15:8] = 8'hAA;
        rx_hit[1] = 1'b1;
        #1;
        check8("pushpop_head", rdata, 8'h01);
        tick();
        rden = 1'b0;
        rx_hit[1] = 1'b0;
        read_reg(BASE + 16'd6, 1'b0, d);  check8("pushpop_count", d, 8'h08);
        read_reg(BASE + 16'd5, 1'b0, d);  check8("pushpop_status", d, 8'h04);
        for (int i = 0; i < 8; i++) begin
            read_reg(BASE + 16'd4, 1'b1, d);
            exp = (i < 7) ? 8'(i + 2) : 8'hAA;
            check8("drain1", d, exp);
        end
        read_reg(BASE + 16'd5, 1'b0, d);  check8("drained_status", d, 8'h02);

        // Flush discards contents and a same-cycle push
        push(1, 8'h11);
        push(1, 8'h22);
        addr  = BASE + 16'd7;
        wdata = 8'h01;
        wren  = 1'b1;
        rx_data[15:8] = 8'h33;
        rx_hit[1] = 1'b1;
        tick();
        wren = 1'b0;
        rx_hit[1] = 1'b0;
        read_reg(BASE + 16'd6, 1'b0, d);  check8("flush_count", d, 8'h00);
        read_reg(BASE + 16'd4, 1'b0, d);  check8("flush_data", d, 8'h00);

        // TX on channel 1 with drop and completion
        wr_reg(BASE + 16'd4, 8'hF4);
        check1("send_pulse", tx_send[1], 1'b1);
        check1("send_other", tx_send[0], 1'b0);
        check8("send_cmd", tx_cmd[15:8], 8'hF4);
        read_reg(BASE + 16'd5, 1'b0, d);  check8("busy_status", d, 8'h12);
        check1("send_low", tx_send[1], 1'b0);
        wr_reg(BASE + 16'd4, 8'hFF);
        check8("drop_cmd", tx_cmd[15:8], 8'hF4);
        check1("drop_nosend", tx_send[1], 1'b0);
        read_reg(BASE + 16'd5, 1'b0, d);  check8("drop_status", d, 8'h52);
        tx_done[1] = 1'b1;
        tick();
        tx_done[1] = 1'b0;
        read_reg(BASE + 16'd5, 1'b0, d);  check8("done_status", d, 8'h43);

        // Timeout: error lands 16 cycles after entering WAIT
        wr_reg(BASE + 16'd7, 8'h02);
        read_reg(BASE + 16'd5, 1'b0, d);  check8("clr_status", d, 8'h02);
        wr_reg(BASE + 16'd4, 8'h55);
        addr = BASE + 16'd5;
        repeat (16) tick();
        check8("tmo_before", rdata, 8'h12);
        tick();
        check8("tmo_at", rdata, 8'h22);
        tx_done[1] = 1'b1;
        tick();
        tx_done[1] = 1'b0;
        check8("idle_strobe", rdata, 8'h22);
        wr_reg(BASE + 16'd7, 8'h02);
        read_reg(BASE + 16'd5, 1'b0, d);  check8("tmo_clr", d, 8'h02);

        // Done and error together: error wins
        wr_reg(BASE + 16'd4, 8'h66);
        tick();
        tx_done[1] = 1'b1;
        tx_err[1]  = 1'b1;
        tick();
        tx_done[1] = 1'b0;
        tx_err[1]  = 1'b0;
        read_reg(BASE + 16'd5, 1'b0, d);  check8("both_status", d, 8'h22);
        check8("both_cmd", tx_cmd[15:8], 8'h66);

        // Asynchronous reset during WAIT with data queued
        wr_reg(BASE + 16'd7, 8'h02);
        push(1, 8'hA1);
        push(1, 8'hA2);
        push(1, 8'hA3);
        wr_reg(BASE + 16'd4, 8'h77);
        tick();
        addr = BASE + 16'd6;
        #1;
        check8("pre_rst_count", rdata, 8'h03);
        rst_n = 1'b0;
        #1;
        check8("arst_count", rdata, 8'h00);
        check1("arst_send", tx_send[1], 1'b0);
        check8("arst_cmd", tx_cmd[15:8], 8'h00);
        addr = BASE + 16'd5;
        #1;
        check8("arst_status1", rdata, 8'h02);
        addr = BASE + 16'd1;
        #1;
        check8("arst_status0", rdata, 8'h02);
        check1("arst_irq", irq, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        check1("post_rst_send", tx_send[1], 1'b0);
        read_reg(BASE + 16'd5, 1'b0, d);  check8("post_rst_status", d, 8'h02);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/io_ps2_hub.md
# io_ps2_hub

Memory-mapped PS/2 hub for the EasyCPU I/O page. It replaces the single-byte `keybxt`/`msdata` latches, which lose bytes, with CHANNELS independent receive FIFOs. Each channel also gets a command-transmit FSM with completion, error and timeout status, plus a level interrupt. It sits between the CPU bus decoder and the `ps2keyboard` instances: one channel per PS/2 device, all on the CPU clock.

## Interface
- CHANNELS, 2: number of PS/2 channels, 1..8.
- DEPTH, 8: RX FIFO depth per channel; power of 2, 2..64.
- BASE, 16'hFFA0: address of channel 0. Channel c occupies BASE+4c .. BASE+4c+3.
- TX_TIMEOUT, 2_500_000: cycles from send to forced error. Must be at least 2.
- CLOCK  in  1  CPU clock; all logic on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- ADDR  in  16  CPU address.
- WDATA  in  8  CPU write data.
- WREN  in  1  CPU write strobe, one cycle.
- RDEN  in  1  CPU read strobe, one cycle; qualifies FIFO pop.
- RDATA  out  8  read data; combinational from ADDR; 0 when SEL=0.
- SEL  out  1  ADDR falls inside the hub window.
- RX_DATA  in  8*CHANNELS  received byte; channel c at [8c+7:8c].
- RX_HIT  in  CHANNELS  one-cycle strobe marking RX_DATA valid.
- TX_CMD  out  8*CHANNELS  command byte to the PS/2 device.
- TX_SEND  out  CHANNELS  one-cycle send pulse.
- TX_DONE  in  CHANNELS  command-was-sent strobe.
- TX_ERR  in  CHANNELS  communication-timeout strobe.
- IRQ  out  1  level interrupt; OR over c of (irq_en[c] & !empty[c]).

## Operation
Per-channel register map (offset from BASE+4c):
- +0 read: DATA, the FIFO head, or 0 when empty. If RDEN is high and the FIFO is not empty, the head is popped.
- +0 write: TX command. Latch the byte into TX_CMD and start the TX FSM. If the FSM is not IDLE, ignore the write and set `cmd_drop`.
- +1 read: STATUS = {irq_en, cmd_drop, tx_err, tx_busy, overflow, full, empty, tx_done}. All bits are sticky except tx_busy, full and empty.
- +2 read: COUNT, the number of stored bytes, 0..DEPTH, zero-extended.
- +3 write: CTRL.
  - bit0 = flush FIFO.
  - bit1 = clear the sticky bits overflow, tx_err, tx_done and cmd_drop.
  - bit2 = irq_en value.
- +3 read: {7'b0, irq_en}.
- Unused offsets read 0; writes to them are ignored.

RX FIFO (circular, rd/wr pointers log2(DEPTH) bits wide, count log2(DEPTH)+1 bits wide):
- Push only: when RX_HIT is high and the FIFO is not full, store the byte. When full, drop the byte and set overflow.
- Push and pop in the same cycle: both are performed and count is unchanged. This holds even when full, so no overflow is flagged. When empty, the pop is a no-op and the push lands.
- Flush: resets pointers and count. A push in the same cycle is discarded.

TX FSM:
- IDLE, on accepted command write → SEND.
- SEND: TX_SEND=1 for exactly one cycle → WAIT. The timeout counter is cleared on entry to WAIT.
- WAIT:
  - TX_DONE → set tx_done, go to IDLE.
  - TX_ERR, or counter = TX_TIMEOUT-1 → set tx_err, go to IDLE.
  - TX_DONE and TX_ERR in the same cycle: TX_ERR wins.
- tx_busy = (state != IDLE).
- Strobes arriving in IDLE are ignored.

## Timing
- Reset values:
  - RDATA 0 when SEL=0.
  - SEL purely combinational from ADDR.
  - TX_SEND 0, TX_CMD 0, IRQ 0.
  - All FIFOs empty, all sticky bits 0, irq_en 0, FSMs IDLE.
- Reset asserted mid-operation: any in-flight TX is abandoned with no TX_SEND; FIFO contents are lost.
- Read latency: 0 cycles. RDATA reflects the state before the edge; the pop takes effect at the edge.
- RX_HIT to visibility: a byte pushed at edge N is readable from cycle N+1; COUNT and IRQ update at N+1.
- Command write at edge N → TX_SEND high during cycle N+1. Earliest next accepted command: edge N+2 plus completion.
- Simultaneous CTRL bit1 clear and a new sticky event in one cycle: the event wins (bit stays set).

## Structure
- Package `io_ps2_pkg`:
  - register offsets OFS_DATA=0, OFS_STATUS=1, OFS_COUNT=2, OFS_CTRL=3;
  - STATUS bit indices;
  - TX state enum {IDLE, SEND, WAIT}.
- Sub-module `io_ps2_chan`: one channel's FIFO, TX FSM, sticky bits and local register mux.
  - Instantiated CHANNELS times via generate.
  - The top level does window decode, channel select (ADDR[4:2] relative to BASE), the RDATA mux and the IRQ OR.

## Test plan
- Reset, then read BASE+1 → 8'h02 (empty only), and BASE+2 → 0; IRQ=0.
- Push 0x1C and 0xF0 on ch0, set CTRL=0x04 → IRQ=1, COUNT=2.
  - Read BASE with RDEN → 0x1C, then 0xF0; next read → 0.
  - IRQ falls the cycle after the second pop.
- Push DEPTH+1 bytes (0x01..0x09) on ch1 with no reads → COUNT=8, overflow=1, last byte 0x09 dropped. A simultaneous push and pop when full keeps COUNT=8 with overflow unchanged.
- Write 0xF4 to BASE+4 → TX_CMD[15:8]=0xF4, one-cycle TX_SEND[1], tx_busy=1.
  - A second write of 0xFF while busy is ignored and sets cmd_drop.
  - TX_DONE → STATUS bit0=1, busy=0.
- TX with no TX_DONE/TX_ERR (TX_TIMEOUT=16) → tx_err set exactly 16 cycles after entering WAIT. CTRL=0x02 clears it.
- Assert RESET_N low during WAIT with the FIFO holding 3 bytes → TX_SEND=0, COUNT=0, STATUS=0x02 immediately, without waiting for a clock edge.
